// File: rtl/uart_axi_pkg.sv
// Shared types and helpers for the uart-to-axi controller: command opcodes,
// error codes, ASCII constants, parser states and a hex-digit decoder.
package uart_axi_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_WR   = 2'd1,
        OP_RD   = 2'd2,
        OP_BR   = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BADCHAR = 2'd1,
        ERR_OVERRUN = 2'd2
    } err_code_e;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_OP_B = 4'd1,
        ST_SP1  = 4'd2,
        ST_ADDR = 4'd3,
        ST_SP2  = 4'd4,
        ST_DATA = 4'd5,
        ST_LEN  = 4'd6,
        ST_EOL  = 4'd7,
        ST_HOLD = 4'd8,
        ST_SKIP = 4'd9
    } parse_st_e;

    localparam logic [7:0] C_CR = 8'h0D;
    localparam logic [7:0] C_LF = 8'h0A;
    localparam logic [7:0] C_SP = 8'h20;

    // Returns {valid, nibble}; valid is 0 for anything outside 0-9, a-f, A-F.
    function automatic logic [4:0] hex2nib(input logic [7:0] c);
        logic [7:0] v;
        if (c >= 8'h30 && c <= 8'h39) begin
            v = c - 8'h30;
            return {1'b1, v[3:0]};
        end else if (c >= 8'h61 && c <= 8'h66) begin
            v = c - 8'h57;
            return {1'b1, v[3:0]};
        end else if (c >= 8'h41 && c <= 8'h46) begin
            v = c - 8'h37;
            return {1'b1, v[3:0]};
        end
        return 5'd0;
    endfunction

endpackage

// File: rtl/uart_cmd_parser.sv
// Decodes ASCII write / read / burst-read lines from the UART into command
// descriptors for the AXI engine; malformed lines are skipped and flagged.
module uart_cmd_parser
    import uart_axi_pkg::*;
#(
    parameter int P_ADDR_W = 16,
    parameter int P_DATA_W = 32
) (
    input  logic                aclk,
    input  logic                rstn,
    input  logic [7:0]          i_rx_data,
    input  logic                i_rx_valid,
    output logic                o_cmd_valid,
    input  logic                i_cmd_ready,
    output logic [1:0]          o_cmd_op,
    output logic [P_ADDR_W-1:0] o_cmd_addr,
    output logic [P_DATA_W-1:0] o_cmd_wdata,
    output logic [7:0]          o_cmd_len,
    output logic                o_err,
    output logic [1:0]          o_err_code
);

    localparam int L_ADDR_DIG = P_ADDR_W / 4;
    localparam int L_DATA_DIG = P_DATA_W / 4;
    localparam int L_MAX_DIG  = (L_ADDR_DIG > L_DATA_DIG) ? L_ADDR_DIG : L_DATA_DIG;
    localparam int L_CNT_W    = $clog2(L_MAX_DIG + 1);

    localparam logic [L_CNT_W-1:0] L_ADDR_LAST = L_CNT_W'(L_ADDR_DIG - 1);
    localparam logic [L_CNT_W-1:0] L_DATA_LAST = L_CNT_W'(L_DATA_DIG - 1);
    localparam logic [L_CNT_W-1:0] L_LEN_LAST  = L_CNT_W'(1);

    parse_st_e             r_state;
    cmd_op_e               r_op;
    logic [P_ADDR_W-1:0]   r_addr;
    logic [P_DATA_W-1:0]   r_wdata;
    logic [7:0]            r_len;
    logic [L_CNT_W-1:0]    r_cnt;
    logic                  r_valid;
    logic                  r_err;
    err_code_e             r_err_code;

    logic [4:0]            w_hex;
    logic                  w_is_hex;
    logic [3:0]            w_nib;
    logic                  w_is_cr;
    logic                  w_bad;

    assign w_hex    = hex2nib(i_rx_data);
    assign w_is_hex = w_hex[4];
    assign w_nib    = w_hex[3:0];
    assign w_is_cr  = (i_rx_data == C_CR);

    // Whether the current byte breaks the grammar in the current state.
    always_comb begin
        w_bad = 1'b0;
        case (r_state)
            ST_IDLE: begin
                case (i_rx_data)
                    "w", "W", "r", "R", "b", "B", C_CR, C_LF, C_SP: w_bad = 1'b0;
                    default:                                        w_bad = 1'b1;
                endcase
            end
            ST_OP_B:                  w_bad = !(i_rx_data == "r" || i_rx_data == "R");
            ST_SP1, ST_SP2:           w_bad = (i_rx_data != C_SP);
            ST_ADDR, ST_DATA, ST_LEN: w_bad = !w_is_hex;
            ST_EOL:                   w_bad = !w_is_cr;
            default:                  w_bad = 1'b0;
        endcase
    end

    always_ff @(posedge aclk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_NONE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_err <= 1'b0;
            if (r_state == ST_HOLD) begin
                // A byte arriving while a descriptor is pending is always an overrun,
                // even on the very edge the handshake completes.
                if (i_cmd_ready) begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_op    <= OP_NONE;
                    r_addr  <= '0;
                    r_wdata <= '0;
                    r_len   <= '0;
                    r_cnt   <= '0;
                end
                if (i_rx_valid) begin
                    r_err      <= 1'b1;
                    r_err_code <= ERR_OVERRUN;
                end
            end else if (i_rx_valid) begin
                if (w_bad) begin
                    r_err      <= 1'b1;
                    r_err_code <= ERR_BADCHAR;
                    r_op       <= OP_NONE;
                    r_addr     <= '0;
                    r_wdata    <= '0;
                    r_len      <= '0;
                    r_cnt      <= '0;
                    r_state    <= w_is_cr ? ST_IDLE : ST_SKIP;
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            case (i_rx_data)
                                "w", "W": begin r_op <= OP_WR; r_state <= ST_SP1; end
                                "r", "R": begin r_op <= OP_RD; r_state <= ST_SP1; end
                                "b", "B": r_state <= ST_OP_B;
                                default:  r_state <= ST_IDLE;
                            endcase
                        end
                        ST_OP_B: begin
                            r_op    <= OP_BR;
                            r_state <= ST_SP1;
                        end
                        ST_SP1: begin
                            r_cnt   <= '0;
                            r_state <= ST_ADDR;
                        end
                        ST_ADDR: begin
                            r_addr <= {r_addr[P_ADDR_W-5:0], w_nib};
                            if (r_cnt == L_ADDR_LAST) begin
                                r_cnt   <= '0;
                                r_state <= (r_op == OP_RD) ? ST_EOL : ST_SP2;
                            end else begin
                                r_cnt <= r_cnt + L_CNT_W'(1);
                            end
                        end
                        ST_SP2: r_state <= (r_op == OP_WR) ? ST_DATA : ST_LEN;
                        ST_DATA: begin
                            r_wdata <= {r_wdata[P_DATA_W-5:0], w_nib};
                            if (r_cnt == L_DATA_LAST) begin
                                r_cnt   <= '0;
                                r_state <= ST_EOL;
                            end else begin
                                r_cnt <= r_cnt + L_CNT_W'(1);
                            end
                        end
                        ST_LEN: begin
                            r_len <= {r_len[3:0], w_nib};
                            if (r_cnt == L_LEN_LAST) begin
                                r_cnt   <= '0;
                                r_state <= ST_EOL;
                            end else begin
                                r_cnt <= r_cnt + L_CNT_W'(1);
                            end
                        end
                        ST_EOL: begin
                            r_valid <= 1'b1;
                            r_state <= ST_HOLD;
                        end
                        ST_SKIP: begin
                            if (w_is_cr) r_state <= ST_IDLE;
                        end
                        default: r_state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    assign o_cmd_valid = r_valid;
    assign o_cmd_op    = r_op;
    assign o_cmd_addr  = r_addr;
    assign o_cmd_wdata = r_wdata;
    assign o_cmd_len   = r_len;
    assign o_err       = r_err;
    assign o_err_code  = r_err_code;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed self-checking bench for uart_cmd_parser: feeds ASCII lines and
// checks descriptors, error pulses, overrun and reset behaviour.
module tb_uart_cmd_parser;

    logic        aclk;
    logic        rstn;
    logic [7:0]  rxData;
    logic        rxValid;
    logic        cmdValid;
    logic        cmdReady;
    logic [1:0]  cmdOp;
    logic [15:0] cmdAddr;
    logic [31:0] cmdWdata;
    logic [7:0]  cmdLen;
    logic        err;
    logic [1:0]  errCode;

    int checks   = 0;
    int failures = 0;

    int          xferCount   = 0;
    int          errCount    = 0;
    logic [1:0]  lastErrCode = 2'd0;
    logic [1:0]  capOp;
    logic [15:0] capAddr;
    logic [31:0] capWdata;
    logic [7:0]  capLen;

    uart_cmd_parser #(.P_ADDR_W(16), .P_DATA_W(32)) dut (
        .aclk        (aclk),
        .rstn        (rstn),
        .i_rx_data   (rxData),
        .i_rx_valid  (rxValid),
        .o_cmd_valid (cmdValid),
        .i_cmd_ready (cmdReady),
        .o_cmd_op    (cmdOp),
        .o_cmd_addr  (cmdAddr),
        .o_cmd_wdata (cmdWdata),
        .o_cmd_len   (cmdLen),
        .o_err       (err),
        .o_err_code  (errCode)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Observe on the falling edge: one err count per high cycle, one transfer per handshake.
    always @(negedge aclk) begin
        if (err) begin
            errCount    = errCount + 1;
            lastErrCode = errCode;
        end
        if (cmdValid && cmdReady) begin
            xferCount = xferCount + 1;
            capOp     = cmdOp;
            capAddr   = cmdAddr;
            capWdata  = cmdWdata;
            capLen    = cmdLen;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        @(posedge aclk);
        #1;
        rxData  = b;
        rxValid = 1'b1;
        @(posedge aclk);
        #1;
        rxValid = 1'b0;
    endtask

    task automatic applyStimulus(input string s);
        for (int i = 0; i < s.len(); i++) sendByte(s[i]);
        repeat (4) @(posedge aclk);
        #1;
    endtask

    int xferBase;
    int errBase;

    initial begin
        rstn     = 1'b0;
        rxData   = 8'h00;
        rxValid  = 1'b0;
        cmdReady = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        checkOutput("rst_valid", 64'(cmdValid), 64'd0);
        checkOutput("rst_op",    64'(cmdOp),    64'd0);
        checkOutput("rst_addr",  64'(cmdAddr),  64'd0);
        checkOutput("rst_wdata", 64'(cmdWdata), 64'd0);
        checkOutput("rst_len",   64'(cmdLen),   64'd0);
        checkOutput("rst_err",   64'(err),      64'd0);
        checkOutput("rst_code",  64'(errCode),  64'd0);
        rstn = 1'b1;

        $display("[TB] write command");
        xferBase = xferCount; errBase = errCount;
        applyStimulus("w 0FEC 1234ABCD\r");
        checkOutput("wr_xfers", 64'(xferCount - xferBase), 64'd1);
        checkOutput("wr_op",    64'(capOp),    64'd1);
        checkOutput("wr_addr",  64'(capAddr),  64'h0FEC);
        checkOutput("wr_wdata", 64'(capWdata), 64'h1234ABCD);
        checkOutput("wr_len",   64'(capLen),   64'd0);
        checkOutput("wr_noerr", 64'(errCount - errBase), 64'd0);
        checkOutput("wr_valid_after", 64'(cmdValid), 64'd0);

        $display("[TB] read and burst read");
        xferBase = xferCount;
        applyStimulus("r 0fec\r");
        checkOutput("rd_xfers", 64'(xferCount - xferBase), 64'd1);
        checkOutput("rd_op",    64'(capOp),    64'd2);
        checkOutput("rd_addr",  64'(capAddr),  64'h0FEC);
        checkOutput("rd_wdata", 64'(capWdata), 64'd0);
        checkOutput("rd_len",   64'(capLen),   64'd0);
        applyStimulus("br 0000 03\r");
        checkOutput("br_xfers", 64'(xferCount - xferBase), 64'd2);
        checkOutput("br_op",    64'(capOp),    64'd3);
        checkOutput("br_addr",  64'(capAddr),  64'h0000);
        checkOutput("br_wdata", 64'(capWdata), 64'd0);
        checkOutput("br_len",   64'(capLen),   64'h03);
        checkOutput("rdbr_noerr", 64'(errCount - errBase), 64'd0);

        $display("[TB] bad character then recovery");
        xferBase = xferCount; errBase = errCount;
        applyStimulus("w 00g4 11111111\r");
        checkOutput("bad_errs",   64'(errCount - errBase), 64'd1);
        checkOutput("bad_code",   64'(lastErrCode), 64'd1);
        checkOutput("bad_xfers",  64'(xferCount - xferBase), 64'd0);
        checkOutput("bad_hold_code", 64'(errCode), 64'd1);
        applyStimulus("r 0004\r");
        checkOutput("rec_xfers", 64'(xferCount - xferBase), 64'd1);
        checkOutput("rec_op",    64'(capOp),   64'd2);
        checkOutput("rec_addr",  64'(capAddr), 64'h0004);

        $display("[TB] overrun while holding");
        cmdReady = 1'b0;
        xferBase = xferCount; errBase = errCount;
        applyStimulus("r 0008\r");
        checkOutput("hold_valid", 64'(cmdValid), 64'd1);
        checkOutput("hold_addr",  64'(cmdAddr),  64'h0008);
        checkOutput("hold_op",    64'(cmdOp),    64'd2);
        applyStimulus("x");
        checkOutput("ovr_errs",  64'(errCount - errBase), 64'd1);
        checkOutput("ovr_code",  64'(lastErrCode), 64'd2);
        checkOutput("ovr_valid", 64'(cmdValid), 64'd1);
        checkOutput("ovr_addr",  64'(cmdAddr),  64'h0008);
        checkOutput("ovr_op",    64'(cmdOp),    64'd2);
        checkOutput("ovr_noxfer", 64'(xferCount - xferBase), 64'd0);
        cmdReady = 1'b1;
        repeat (4) @(posedge aclk);
        #1;
        checkOutput("ovr_xfers",  64'(xferCount - xferBase), 64'd1);
        checkOutput("ovr_capaddr", 64'(capAddr), 64'h0008);
        checkOutput("ovr_released", 64'(cmdValid), 64'd0);

        $display("[TB] extra data digit");
        xferBase = xferCount; errBase = errCount;
        applyStimulus("w 0000 123456789\r");
        checkOutput("long_errs",  64'(errCount - errBase), 64'd1);
        checkOutput("long_code",  64'(lastErrCode), 64'd1);
        checkOutput("long_xfers", 64'(xferCount - xferBase), 64'd0);

        $display("[TB] reset mid-line");
        xferBase = xferCount; errBase = errCount;
        applyStimulus("w 00");
        rstn = 1'b0;
        #1;
        checkOutput("mrst_valid", 64'(cmdValid), 64'd0);
        checkOutput("mrst_op",    64'(cmdOp),    64'd0);
        checkOutput("mrst_addr",  64'(cmdAddr),  64'd0);
        checkOutput("mrst_code",  64'(errCode),  64'd0);
        repeat (2) @(posedge aclk);
        #1;
        rstn = 1'b1;
        applyStimulus("r 0010\r");
        checkOutput("mrst_xfers", 64'(xferCount - xferBase), 64'd1);
        checkOutput("mrst_rdop",  64'(capOp),   64'd2);
        checkOutput("mrst_rdaddr", 64'(capAddr), 64'h0010);
        checkOutput("mrst_noerr", 64'(errCount - errBase), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
